// File: rtl/draw_port_arbiter.sv
// Arbiter sharing the VGA pixel-write port and the map-memory address bus between
// the animation drawers; one requester owns both ports from grant until its job ends.
module draw_port_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned ADDR_W  = 15,
    parameter bit          RR      = 1'b1,
    parameter int unsigned TIMEOUT = 32000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ-1:0]        iDone,
    input  logic [NUM_REQ*8-1:0]      iX,
    input  logic [NUM_REQ*7-1:0]      iY,
    input  logic [NUM_REQ*9-1:0]      iColour,
    input  logic [NUM_REQ-1:0]        iPlot,
    input  logic [NUM_REQ*ADDR_W-1:0] iAddr,
    output logic [NUM_REQ-1:0]        oGrant,
    output logic [2:0]                oGrantId,
    output logic                      oBusy,
    output logic [7:0]                oX,
    output logic [6:0]                oY,
    output logic [8:0]                oColour,
    output logic                      oPlot,
    output logic [ADDR_W-1:0]         oAddress,
    output logic                      oTimeout
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t      state;
    logic [15:0] holdCnt;
    logic [2:0]  last;

    logic [7:0]  reqPad;
    logic [2:0]  idx;
    logic [2:0]  winner;
    logic        found;

    logic              selReq;
    logic              selDone;
    logic              selPlot;
    logic [7:0]        selX;
    logic [6:0]        selY;
    logic [8:0]        selColour;
    logic [ADDR_W-1:0] selAddr;
    logic              timeoutHit;

    // Round-robin searches from the slot after the last winner; fixed priority from slot 0.
    always_comb begin
        reqPad = 8'(iReq);
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (RR) idx = 3'((32'(last) + 1 + i) % NUM_REQ);
            else    idx = 3'(i);
            if (!found && reqPad[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        selReq    = 1'b0;
        selDone   = 1'b0;
        selPlot   = 1'b0;
        selX      = '0;
        selY      = '0;
        selColour = '0;
        selAddr   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (oGrantId == 3'(k)) begin
                selReq    = iReq[k];
                selDone   = iDone[k];
                selPlot   = iPlot[k];
                selX      = iX[8*k +: 8];
                selY      = iY[7*k +: 7];
                selColour = iColour[9*k +: 9];
                selAddr   = iAddr[ADDR_W*k +: ADDR_W];
            end
        end
    end

    assign oAddress   = oBusy ? selAddr : '0;
    assign timeoutHit = (TIMEOUT != 0) && (holdCnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            holdCnt  <= '0;
            last     <= 3'(NUM_REQ - 1);
            oGrant   <= '0;
            oGrantId <= '0;
            oBusy    <= 1'b0;
            oX       <= '0;
            oY       <= '0;
            oColour  <= '0;
            oPlot    <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    oPlot   <= 1'b0;
                    holdCnt <= '0;
                    if (found) begin
                        oGrant   <= NUM_REQ'(1) << winner;
                        oGrantId <= winner;
                        oBusy    <= 1'b1;
                        if (RR) last <= winner;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // The final pixel travels with iDone, so it is registered on the release edge too.
                    oX      <= selX;
                    oY      <= selY;
                    oColour <= selColour;
                    oPlot   <= selPlot;
                    if (holdCnt != '1) holdCnt <= holdCnt + 16'd1;
                    if (selDone || !selReq || timeoutHit) begin
                        oGrant   <= '0;
                        oGrantId <= '0;
                        oBusy    <= 1'b0;
                        oTimeout <= !(selDone || !selReq);
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    oPlot   <= 1'b0;
                    holdCnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench: round-robin instance with short timeout plus a fixed-priority
// instance with timeout disabled, both driven from the same request bundle.
module tb_draw_port_arbiter;

    localparam int unsigned N  = 5;
    localparam int unsigned AW = 15;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    iReq, iDone, iPlot;
    logic [N*8-1:0]  iX;
    logic [N*7-1:0]  iY;
    logic [N*9-1:0]  iColour;
    logic [N*AW-1:0] iAddr;

    logic [N-1:0]  aGrant, bGrant;
    logic [2:0]    aId, bId;
    logic          aBusy, bBusy, aPlot, bPlot, aTo, bTo;
    logic [7:0]    aX, bX;
    logic [6:0]    aY, bY;
    logic [8:0]    aCol, bCol;
    logic [AW-1:0] aAddr, bAddr;

    int vectors = 0;
    int fails   = 0;

    always #5 clock = ~clock;

    draw_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .RR(1'b1), .TIMEOUT(8)) dutA (
        .clock(clock), .reset(reset), .iReq(iReq), .iDone(iDone), .iX(iX), .iY(iY),
        .iColour(iColour), .iPlot(iPlot), .iAddr(iAddr), .oGrant(aGrant), .oGrantId(aId),
        .oBusy(aBusy), .oX(aX), .oY(aY), .oColour(aCol), .oPlot(aPlot), .oAddress(aAddr),
        .oTimeout(aTo));

    draw_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .RR(1'b0), .TIMEOUT(0)) dutB (
        .clock(clock), .reset(reset), .iReq(iReq), .iDone(iDone), .iX(iX), .iY(iY),
        .iColour(iColour), .iPlot(iPlot), .iAddr(iAddr), .oGrant(bGrant), .oGrantId(bId),
        .oBusy(bBusy), .oX(bX), .oY(bY), .oColour(bCol), .oPlot(bPlot), .oAddress(bAddr),
        .oTimeout(bTo));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setPix(input int k, input logic [7:0] x, input logic [6:0] y,
                          input logic [8:0] c, input logic p, input logic [AW-1:0] a);
        iX[8*k +: 8]       = x;
        iY[7*k +: 7]       = y;
        iColour[9*k +: 9]  = c;
        iPlot[k]           = p;
        iAddr[AW*k +: AW]  = a;
    endtask

    task automatic doReset();
        reset = 1'b1;
        iReq = '0; iDone = '0; iPlot = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int order[6];
        order = '{0, 1, 2, 3, 4, 0};
        reset = 1'b1;
        iReq = '0; iDone = '0; iPlot = '0;
        iX = '0; iY = '0; iColour = '0; iAddr = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_grant", 32'(aGrant), 0);
        check("rst_id", 32'(aId), 0);
        check("rst_busy", 32'(aBusy), 0);
        check("rst_plot", 32'(aPlot), 0);
        check("rst_x", 32'(aX), 0);
        check("rst_addr", 32'(aAddr), 0);
        check("rst_timeout", 32'(aTo), 0);

        // single requester with pixel stream
        iReq = 5'b00100;
        tick();
        check("t1_grant", 32'(aGrant), 32'b00100);
        check("t1_id", 32'(aId), 2);
        check("t1_busy", 32'(aBusy), 1);
        setPix(2, 8'd10, 7'd20, 9'h1FF, 1'b1, 15'h1234);
        #1;
        check("t1_addr", 32'(aAddr), 32'h1234);
        tick();
        check("t1_x", 32'(aX), 10);
        check("t1_y", 32'(aY), 20);
        check("t1_col", 32'(aCol), 32'h1FF);
        check("t1_plot", 32'(aPlot), 1);
        setPix(2, 8'd11, 7'd21, 9'h0AA, 1'b1, 15'h1234);
        iDone = 5'b00100;
        tick();
        check("t1_final_plot", 32'(aPlot), 1);
        check("t1_final_x", 32'(aX), 11);
        check("t1_rel_busy", 32'(aBusy), 0);
        check("t1_rel_grant", 32'(aGrant), 0);
        check("t1_rel_addr", 32'(aAddr), 0);
        iDone = '0; iReq = '0; iPlot = '0;
        tick();
        check("t1_idle_plot", 32'(aPlot), 0);
        check("t1_hold_x", 32'(aX), 11);
        check("t1_hold_col", 32'(aCol), 32'h0AA);

        // round-robin order with gap
        doReset();
        iReq = 5'b11111;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("t2_rr_id", 32'(aId), 32'(order[i]));
            check("t2_rr_grant", 32'(aGrant), 32'(1) << order[i]);
            iDone = 5'(1 << order[i]);
            tick();
            iDone = '0;
            check("t2_gap_busy", 32'(aBusy), 0);
            tick();
            check("t2_gap2_busy", 32'(aBusy), 0);
            tick();
        end

        // fixed priority
        doReset();
        iReq = 5'b10110;
        tick();
        check("t3_fp_1", 32'(bId), 1);
        iDone = 5'b00010; iReq = 5'b10100;
        tick();
        iDone = '0;
        tick();
        tick();
        check("t3_fp_2", 32'(bId), 2);
        iDone = 5'b00100; iReq = 5'b10000;
        tick();
        iDone = '0;
        tick();
        tick();
        check("t3_fp_4", 32'(bGrant), 32'b10000);
        iDone = 5'b10000; iReq = '0;
        tick();
        iDone = '0;
        tick();

        // isolation of non-granted requester
        doReset();
        iReq = 5'b00001;
        tick();
        check("t4_id", 32'(aId), 0);
        setPix(0, 8'd5, 7'd1, 9'h011, 1'b0, 15'h0AAA);
        setPix(3, 8'd99, 7'd9, 9'h199, 1'b1, 15'h7FFF);
        #1;
        check("t4_addr", 32'(aAddr), 32'h0AAA);
        tick();
        check("t4_plot0", 32'(aPlot), 0);
        check("t4_x0", 32'(aX), 5);
        setPix(0, 8'd6, 7'd2, 9'h022, 1'b1, 15'h0AAA);
        setPix(3, 8'd77, 7'd7, 9'h177, 1'b0, 15'h1111);
        tick();
        check("t4_plot1", 32'(aPlot), 1);
        check("t4_x1", 32'(aX), 6);
        check("t4_addr2", 32'(aAddr), 32'h0AAA);
        iReq = '0; iPlot = '0;
        tick();
        check("t4_drop_busy", 32'(aBusy), 0);
        tick();

        // timeout
        doReset();
        iReq = 5'b00010;
        tick();
        check("t5_id", 32'(aId), 1);
        for (int i = 0; i < 7; i++) tick();
        check("t5_busy7", 32'(aBusy), 1);
        check("t5_to7", 32'(aTo), 0);
        tick();
        check("t5_timeout", 32'(aTo), 1);
        check("t5_dropped", 32'(aBusy), 0);
        check("t5_b_noto", 32'(bTo), 0);
        check("t5_b_busy", 32'(bBusy), 1);
        tick();
        check("t5_to_pulse", 32'(aTo), 0);
        tick();
        check("t5_regrant", 32'(aGrant), 32'b00010);

        // reset mid-grant
        setPix(1, 8'd42, 7'd3, 9'h055, 1'b1, 15'h0333);
        tick();
        check("t6_plot_pre", 32'(aPlot), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iPlot = '0;
        check("t6_grant", 32'(aGrant), 0);
        check("t6_busy", 32'(aBusy), 0);
        check("t6_plot", 32'(aPlot), 0);
        check("t6_x", 32'(aX), 0);
        check("t6_addr", 32'(aAddr), 0);
        iReq = 5'b11111;
        tick();
        check("t6_first", 32'(aId), 0);
        check("t6_first_grant", 32'(aGrant), 32'b00001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
